// File: rtl/noc_params.sv
// Shared NoC parameters: packet format and default input buffer depth.
package noc_params;

  typedef struct packed {
    logic [3:0]  dest;
    logic [7:0]  id;
    logic [15:0] payload;
  } packet_t;

  localparam int INPUT_BUF_DEPTH = 4;

endpackage

// File: rtl/buf_mem.sv
// Packet storage for the input buffer: one write port, async read port, no reset.
module buf_mem
  import noc_params::*;
#(
  parameter int DEPTH = INPUT_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  packet_t          wdata,
  input  logic [PTR_W-1:0] raddr,
  output packet_t          rdata
);

  packet_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/input_buffer.sv
// Per-port show-ahead input FIFO with credit return toward the upstream link.
// Define INPUT_BUFFER_STATS_EN to add saturating accepted/dropped packet counters.
module input_buffer
  import noc_params::*;
#(
  parameter int DEPTH = INPUT_BUF_DEPTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  packet_t          in_pkt,
  output logic             credit_out,
  output logic             buf_empty,
  output packet_t          buf_data,
  input  logic             buf_rd_en,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow_err
`ifdef INPUT_BUFFER_STATS_EN
  ,
  output logic [15:0]      pkt_in_cnt,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             credit_q, ovf_q, ovf_d;
  logic             rd_acc, wr_acc, drop;
  packet_t          rdata;

  assign buf_empty = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));

  // A write into a full buffer is only safe when the same edge frees a slot.
  assign rd_acc = buf_rd_en && !buf_empty;
  assign wr_acc = in_valid && (!full || rd_acc);
  assign drop   = in_valid && full && !rd_acc;

  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= rd_acc;
      ovf_q    <= ovf_d;
    end
  end

  buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (in_pkt),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign buf_data     = buf_empty ? '0 : rdata;
  assign count        = count_q;
  assign credit_out   = credit_q;
  assign overflow_err = ovf_q;

`ifdef INPUT_BUFFER_STATS_EN
  logic [15:0] pkt_in_cnt_q, pkt_in_cnt_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_in_cnt_d = (wr_acc && pkt_in_cnt_q != '1) ? pkt_in_cnt_q + 16'd1 : pkt_in_cnt_q;
    drop_cnt_d   = (drop && drop_cnt_q != '1) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_in_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      pkt_in_cnt_q <= pkt_in_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign pkt_in_cnt = pkt_in_cnt_q;
  assign drop_cnt   = drop_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Scoreboard bench for input_buffer (DEPTH=4): order, flags, credits, overflow, reset.
module tb_input_buffer;
  import noc_params::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  packet_t          in_pkt;
  logic             credit_out;
  logic             buf_empty;
  packet_t          buf_data;
  logic             buf_rd_en;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow_err;
`ifdef INPUT_BUFFER_STATS_EN
  logic [15:0]      pkt_in_cnt;
  logic [7:0]       drop_cnt;
`endif

  int passed = 0;
  int total  = 0;
  packet_t sb[$];

  always #5 clk = ~clk;

  input_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_pkt       (in_pkt),
    .credit_out   (credit_out),
    .buf_empty    (buf_empty),
    .buf_data     (buf_data),
    .buf_rd_en    (buf_rd_en),
    .full         (full),
    .count        (count),
    .overflow_err (overflow_err)
`ifdef INPUT_BUFFER_STATS_EN
    ,
    .pkt_in_cnt   (pkt_in_cnt),
    .drop_cnt     (drop_cnt)
`endif
  );

  function automatic packet_t mkpkt(input int id);
    packet_t p;
    p.dest    = 4'(id * 3 + 1);
    p.id      = 8'(id);
    p.payload = 16'(16'hA500 ^ (id * 16'h0123));
    return p;
  endfunction

  // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_pkt    = '0;
    buf_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (buf_empty !== 1'b1) $display("FAIL reset_empty got %b want 1", buf_empty); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
    total++; if (count !== '0) $display("FAIL reset_count got %0d want 0", count); else passed++;
    total++; if (credit_out !== 1'b0) $display("FAIL reset_credit got %b want 0", credit_out); else passed++;
    total++; if (buf_data !== packet_t'('0)) $display("FAIL reset_data got %h want 0", buf_data); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_err); else passed++;
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_pkt   = mkpkt(base + i);
      sb.push_back(in_pkt);
      tick();
      total++; if (count !== CNT_W'(sb.size())) $display("FAIL fill_count got %0d want %0d", count, sb.size()); else passed++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    packet_t exp;
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      total++; if (buf_data !== exp) $display("FAIL %s_data got %h want %h", tag, buf_data, exp); else passed++;
      buf_rd_en = 1'b1;
      tick();
      total++; if (credit_out !== 1'b1) $display("FAIL %s_credit got %b want 1", tag, credit_out); else passed++;
    end
    buf_rd_en = 1'b0;
    tick();
    total++; if (credit_out !== 1'b0) $display("FAIL %s_credit_end got %b want 0", tag, credit_out); else passed++;
    total++; if (buf_empty !== 1'b1) $display("FAIL %s_empty got %b want 1", tag, buf_empty); else passed++;
  endtask

  task automatic test_fill_drain();
    fill(16, DEPTH);
    total++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else passed++;
    drain("drain");
  endtask

  task automatic test_wrap();
    packet_t exp;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_pkt   = mkpkt(i);
      sb.push_back(in_pkt);
      tick();
      in_valid = 1'b0;
      total++; if (count !== CNT_W'(1)) $display("FAIL wrap_count got %0d want 1", count); else passed++;
      exp = sb.pop_front();
      total++; if (buf_data !== exp) $display("FAIL wrap_data got %h want %h", buf_data, exp); else passed++;
      buf_rd_en = 1'b1;
      tick();
      buf_rd_en = 1'b0;
      total++; if (count !== '0) $display("FAIL wrap_count0 got %0d want 0", count); else passed++;
    end
    tick();
  endtask

  task automatic test_full_simul();
    packet_t exp;
    fill(32, DEPTH);
    exp = sb.pop_front();
    total++; if (buf_data !== exp) $display("FAIL simul_head got %h want %h", buf_data, exp); else passed++;
    in_valid  = 1'b1;
    in_pkt    = mkpkt(99);
    buf_rd_en = 1'b1;
    sb.push_back(in_pkt);
    tick();
    idle_inputs();
    total++; if (count !== CNT_W'(DEPTH)) $display("FAIL simul_count got %0d want %0d", count, DEPTH); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL simul_ovf got %b want 0", overflow_err); else passed++;
    total++; if (credit_out !== 1'b1) $display("FAIL simul_credit got %b want 1", credit_out); else passed++;
    drain("simul");
  endtask

  task automatic test_overflow();
    fill(48, DEPTH);
    in_valid = 1'b1;
    in_pkt   = mkpkt(77);
    tick();
    in_valid = 1'b0;
    total++; if (count !== CNT_W'(DEPTH)) $display("FAIL ovf_count got %0d want %0d", count, DEPTH); else passed++;
    total++; if (overflow_err !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow_err); else passed++;
`ifdef INPUT_BUFFER_STATS_EN
    total++; if (drop_cnt !== 8'd1) $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); else passed++;
`endif
    tick();
    tick();
    drain("ovf");
    total++; if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow_err); else passed++;
  endtask

  task automatic test_empty_pop();
    buf_rd_en = 1'b1;
    tick();
    buf_rd_en = 1'b0;
    total++; if (credit_out !== 1'b0) $display("FAIL epop_credit got %b want 0", credit_out); else passed++;
    total++; if (count !== '0) $display("FAIL epop_count got %0d want 0", count); else passed++;
    // Write and pop on an empty buffer: write wins, no credit, head next cycle.
    in_valid  = 1'b1;
    in_pkt    = mkpkt(5);
    buf_rd_en = 1'b1;
    sb.push_back(in_pkt);
    tick();
    idle_inputs();
    total++; if (credit_out !== 1'b0) $display("FAIL wpop_credit got %b want 0", credit_out); else passed++;
    total++; if (count !== CNT_W'(1)) $display("FAIL wpop_count got %0d want 1", count); else passed++;
    drain("wpop");
  endtask

  task automatic test_reset_mid();
    fill(64, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    total++; if (count !== '0) $display("FAIL rmid_count got %0d want 0", count); else passed++;
    total++; if (buf_empty !== 1'b1) $display("FAIL rmid_empty got %b want 1", buf_empty); else passed++;
    total++; if (overflow_err !== 1'b0) $display("FAIL rmid_ovf got %b want 0", overflow_err); else passed++;
    total++; if (buf_data !== packet_t'('0)) $display("FAIL rmid_data got %h want 0", buf_data); else passed++;
    for (int i = 0; i < 3; i++) begin
      total++; if (credit_out !== 1'b0) $display("FAIL rmid_credit got %b want 0", credit_out); else passed++;
      tick();
    end
`ifdef INPUT_BUFFER_STATS_EN
    total++; if (drop_cnt !== 8'd0) $display("FAIL rmid_drop_cnt got %0d want 0", drop_cnt); else passed++;
    total++; if (pkt_in_cnt !== 16'd0) $display("FAIL rmid_pkt_cnt got %0d want 0", pkt_in_cnt); else passed++;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_overflow();
    test_empty_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
